// File: rtl/bp_me_pkg.sv
// bp_me_pkg: processor configurations, CCE address-map constants and scheduler FSM states
package bp_me_pkg;
  typedef enum logic [1:0] {e_run, e_drain, e_fenced} bp_me_cce_sched_state_e;
  typedef enum logic {e_bp_default_cfg, e_bp_oct_cfg} bp_params_e;
  localparam int dram_base_bit_lp = 31;
  localparam int block_offset_lp = 6;
  localparam int io_cce_bit_lp = 16;
  function automatic int paddr_width_f(bp_params_e c);
    return (c == e_bp_oct_cfg) ? 48 : 40;
  endfunction
  function automatic int num_cce_f(bp_params_e c);
    return (c == e_bp_oct_cfg) ? 8 : 4;
  endfunction
  function automatic int cce_id_width_f(bp_params_e c);
    return (num_cce_f(c) > 1) ? $clog2(num_cce_f(c)) : 1;
  endfunction
endpackage

// File: rtl/bp_me_addr_to_cce_id.sv
// bp_me_addr_to_cce_id: DRAM lines interleave across CCEs by block index, I/O space by a fixed device field
module bp_me_addr_to_cce_id import bp_me_pkg::*; #(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int paddr_width_p = paddr_width_f(bp_params_p),
  localparam int num_cce_p = num_cce_f(bp_params_p),
  localparam int cce_id_width_p = cce_id_width_f(bp_params_p)
) (
  input  logic [paddr_width_p-1:0]  paddr_i,
  output logic [cce_id_width_p-1:0] cce_id_o
);
  logic dram;
  logic [cce_id_width_p-1:0] field;
  logic unused_bits;
  assign dram = |paddr_i[paddr_width_p-1:dram_base_bit_lp];
  assign field = dram ? paddr_i[block_offset_lp +: cce_id_width_p] : paddr_i[io_cce_bit_lp +: cce_id_width_p];
  assign cce_id_o = cce_id_width_p'(int'(field) % num_cce_p);
  assign unused_bits = ^paddr_i;
endmodule

// File: rtl/bp_me_cce_req_scheduler.sv
// bp_me_cce_req_scheduler: round-robin CCE request scheduler with credits and fence drain; stall counter under BP_ME_CCE_SCHED_STATS_EN
module bp_me_cce_req_scheduler import bp_me_pkg::*; #(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_req_p = 2,
  parameter int credits_p = 4,
  localparam int paddr_width_p = paddr_width_f(bp_params_p),
  localparam int cce_id_width_p = cce_id_width_f(bp_params_p),
  localparam int src_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_width_lp = $clog2(credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*paddr_width_p-1:0] req_paddr_i,
  output logic [num_req_p-1:0]               req_ready_o,
  output logic                               out_v_o,
  output logic [paddr_width_p-1:0]           out_paddr_o,
  output logic [cce_id_width_p-1:0]          out_cce_id_o,
  output logic [src_width_lp-1:0]            out_src_o,
  input  logic                               out_ready_i,
  input  logic                               credit_v_i,
  input  logic                               fence_i,
  output logic                               fence_done_o,
  output logic                               err_o,
  output logic [31:0]                        stall_cnt_o
);
  localparam logic [cnt_width_lp-1:0] credits_lp = cnt_width_lp'(credits_p);
  localparam logic [src_width_lp-1:0] last_req_lp = src_width_lp'(num_req_p - 1);
  bp_me_cce_sched_state_e state_r, state_n;
  logic [src_width_lp-1:0] ptr_r, gidx, out_src_r;
  logic found, grant, underflow, out_v_r, out_v_n, err_r;
  logic [cnt_width_lp-1:0] outstanding_r, outstanding_n;
  logic [paddr_width_p-1:0] paddr_a [num_req_p];
  logic [paddr_width_p-1:0] out_paddr_r;
  logic [cce_id_width_p-1:0] cce_id, out_cce_id_r;
  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign paddr_a[i] = req_paddr_i[i*paddr_width_p +: paddr_width_p];
  end
  // scan downward so the requester closest to ptr wins
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req_v_i[src_width_lp'((int'(ptr_r) + k) % num_req_p)]) begin
        found = 1'b1;
        gidx = src_width_lp'((int'(ptr_r) + k) % num_req_p);
      end
    end
  end
  assign grant = reset_n_i && state_r == e_run && !fence_i && (!out_v_r || out_ready_i)
              && outstanding_r < credits_lp && found;
  assign req_ready_o = grant ? (num_req_p'(1) << gidx) : '0;
  assign underflow = credit_v_i && !grant && outstanding_r == '0;
  assign outstanding_n = (grant && !credit_v_i) ? outstanding_r + cnt_width_lp'(1)
                       : (credit_v_i && !grant && !underflow) ? outstanding_r - cnt_width_lp'(1)
                       : outstanding_r;
  assign out_v_n = grant || (out_v_r && !out_ready_i);
  // drain completes on the edge where the last credit and last transfer land
  always_comb begin
    state_n = state_r;
    if (state_r == e_run && fence_i) state_n = e_drain;
    if (state_r == e_drain && !out_v_n && outstanding_n == '0) state_n = e_fenced;
    if (state_r == e_fenced && !fence_i) state_n = e_run;
  end
  bp_me_addr_to_cce_id #(.bp_params_p(bp_params_p)) addr_map (
    .paddr_i  (paddr_a[gidx]),
    .cce_id_o (cce_id)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_run;
      ptr_r <= '0;
      outstanding_r <= '0;
      out_v_r <= 1'b0;
      err_r <= 1'b0;
      out_paddr_r <= '0;
      out_cce_id_r <= '0;
      out_src_r <= '0;
    end else begin
      state_r <= state_n;
      outstanding_r <= outstanding_n;
      out_v_r <= out_v_n;
      err_r <= err_r || underflow;
      if (grant) begin
        ptr_r <= (gidx == last_req_lp) ? '0 : gidx + src_width_lp'(1);
        out_paddr_r <= paddr_a[gidx];
        out_cce_id_r <= cce_id;
        out_src_r <= gidx;
      end
    end
  end
  assign out_v_o = reset_n_i && out_v_r;
  assign out_paddr_o = reset_n_i ? out_paddr_r : '0;
  assign out_cce_id_o = reset_n_i ? out_cce_id_r : '0;
  assign out_src_o = reset_n_i ? out_src_r : '0;
  assign fence_done_o = reset_n_i && state_r == e_fenced;
  assign err_o = reset_n_i && err_r;
`ifdef BP_ME_CCE_SCHED_STATS_EN
  logic [31:0] stall_cnt_r;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) stall_cnt_r <= '0;
    else if (|req_v_i && state_r == e_run && outstanding_r == credits_lp && !(&stall_cnt_r))
      stall_cnt_r <= stall_cnt_r + 32'd1;
  end
  assign stall_cnt_o = reset_n_i ? stall_cnt_r : '0;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_me_cce_req_scheduler.sv
// tb_bp_me_cce_req_scheduler: directed stimulus with a scoreboard queue checked by an output monitor
module tb_bp_me_cce_req_scheduler;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i;
  logic [1:0] req_v_i;
  logic [79:0] req_paddr_i;
  logic [1:0] req_ready_o;
  logic out_v_o;
  logic [39:0] out_paddr_o;
  logic [1:0] out_cce_id_o;
  logic out_src_o;
  logic out_ready_i, credit_v_i, fence_i, fence_done_o, err_o;
  logic [31:0] stall_cnt_o;
  int vectors = 0;
  int miscompares = 0;
  int seq = 0;
  logic [39:0] a0_ovr = '0;
  typedef struct {
    logic [39:0] paddr;
    logic [1:0]  cce;
    logic        src;
  } exp_t;
  exp_t q[$];

  bp_me_cce_req_scheduler dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .req_v_i      (req_v_i),
    .req_paddr_i  (req_paddr_i),
    .req_ready_o  (req_ready_o),
    .out_v_o      (out_v_o),
    .out_paddr_o  (out_paddr_o),
    .out_cce_id_o (out_cce_id_o),
    .out_src_o    (out_src_o),
    .out_ready_i  (out_ready_i),
    .credit_v_i   (credit_v_i),
    .fence_i      (fence_i),
    .fence_done_o (fence_done_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  // default map has 4 CCEs: DRAM by address bits 7:6, I/O by bits 17:16
  function automatic logic [1:0] cce_of(input logic [39:0] a);
    return (a[39:31] != 9'd0) ? a[7:6] : a[17:16];
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic push(input logic [39:0] a, input logic s);
    exp_t e;
    e.paddr = a;
    e.cce = cce_of(a);
    e.src = s;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] rdy);
    logic [39:0] a0, a1;
    seq++;
    a0 = (a0_ovr != '0) ? a0_ovr : 40'h8000_0000 + 40'(seq) * 40'h40;
    a1 = a0 ^ 40'h8003_0000;
    req_v_i = v;
    req_paddr_i = {a1, a0};
    @(negedge clk_i);
    chk("req_ready", req_ready_o, rdy);
    if (rdy[0]) push(a0, 1'b0);
    if (rdy[1]) push(a1, 1'b1);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (reset_n_i && out_v_o && out_ready_i) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_unexpected: got paddr %0h expected no transfer", out_paddr_o);
      end else begin
        e = q.pop_front();
        chk("out_paddr", out_paddr_o, e.paddr);
        chk("out_cce_id", out_cce_id_o, e.cce);
        chk("out_src", out_src_o, e.src);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0;
    req_v_i = 2'b11;
    req_paddr_i = '0;
    out_ready_i = 1'b0;
    credit_v_i = 1'b0;
    fence_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_out_v", out_v_o, 0);
      chk("rst_err", err_o, 0);
    end
    chk("rst_stall", stall_cnt_o, 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    req_v_i = 2'b00;
    // fairness: credit every cycle keeps outstanding at zero
    out_ready_i = 1'b1;
    credit_v_i = 1'b1;
    repeat (3) begin
      cyc(2'b11, 2'b01);
      cyc(2'b11, 2'b10);
    end
    credit_v_i = 1'b0;
    cyc(2'b00, 2'b00);
    chk("fair_err", err_o, 0);
    // credit exhaustion
    repeat (4) cyc(2'b01, 2'b01);
    repeat (2) cyc(2'b01, 2'b00);
    credit_v_i = 1'b1;
    cyc(2'b01, 2'b00);
    credit_v_i = 1'b0;
    cyc(2'b01, 2'b01);
    cyc(2'b01, 2'b00);
`ifdef BP_ME_CCE_SCHED_STATS_EN
    chk("stall_cnt", stall_cnt_o, 4);
`else
    chk("stall_cnt", stall_cnt_o, 0);
`endif
    credit_v_i = 1'b1;
    repeat (4) cyc(2'b00, 2'b00);
    credit_v_i = 1'b0;
    chk("drain_err", err_o, 0);
    // backpressure
    out_ready_i = 1'b0;
    a0_ovr = 40'h8000_0040;
    cyc(2'b01, 2'b01);
    a0_ovr = 40'h8000_0080;
    repeat (5) begin
      cyc(2'b01, 2'b00);
      chk("bp_out_v", out_v_o, 1);
      chk("bp_paddr", out_paddr_o, 40'h8000_0040);
      chk("bp_cce", out_cce_id_o, 1);
      chk("bp_src", out_src_o, 0);
    end
    out_ready_i = 1'b1;
    cyc(2'b01, 2'b01);
    a0_ovr = '0;
    cyc(2'b00, 2'b00);
    // fence with two outstanding
    fence_i = 1'b1;
    cyc(2'b11, 2'b00);
    chk("fence_done_early", fence_done_o, 0);
    cyc(2'b11, 2'b00);
    credit_v_i = 1'b1;
    cyc(2'b11, 2'b00);
    chk("fence_done_one_left", fence_done_o, 0);
    cyc(2'b11, 2'b00);
    credit_v_i = 1'b0;
    chk("fence_done_rise", fence_done_o, 1);
    cyc(2'b11, 2'b00);
    fence_i = 1'b0;
    cyc(2'b11, 2'b00);
    chk("fence_done_fall", fence_done_o, 0);
    cyc(2'b11, 2'b10);
    cyc(2'b11, 2'b01);
    cyc(2'b00, 2'b00);
    // underflow
    credit_v_i = 1'b1;
    repeat (3) cyc(2'b00, 2'b00);
    credit_v_i = 1'b0;
    chk("uf_err_set", err_o, 1);
    cyc(2'b00, 2'b00);
    chk("uf_err_sticky", err_o, 1);
    repeat (4) cyc(2'b01, 2'b01);
    out_ready_i = 1'b0;
    cyc(2'b01, 2'b00);
    chk("uf_err_hold", err_o, 1);
    chk("held_out_v", out_v_o, 1);
    // reset mid-operation discards the held request
    reset_n_i = 1'b0;
    @(negedge clk_i);
    chk("rst2_outs", {req_ready_o, out_v_o, out_paddr_o, out_cce_id_o, out_src_o, err_o, fence_done_o}, 0);
    chk("rst2_stall", stall_cnt_o, 0);
    @(posedge clk_i);
    #1;
    void'(q.pop_back());
    reset_n_i = 1'b1;
    out_ready_i = 1'b1;
    chk("post_rst_out_v", out_v_o, 0);
    chk("post_rst_err", err_o, 0);
    cyc(2'b01, 2'b01);
    cyc(2'b00, 2'b00);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
